solo_squash_input_cond: RTL and testbench

Input conditioner for the solo_squash Caravel integration: the receive-side counterpart to the output/oeb drive path. It takes the raw, asynchronous, bouncy active-low pad inputs (external reset and the four game buttons) plus the firmware `gpio_ready` flag, and produces synchronised, debounced signals for the game core. It also produces a clean, glitch-free `design_reset` that stays asserted until the GPIOs are configured. It sits between the IO pads and `solo_squash` inside the Caravel adapter layer.

---
 rtl/solo_squash_input_cond.sv | 113 +++++++++++
 tb/tb_solo_squash_input_cond.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/solo_squash_input_cond.sv
// Receive-side conditioner for solo_squash: synchronises and debounces the raw
// active-low pads and produces a glitch-free design_reset gated by gpio_ready.
module solo_squash_input_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 50000,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       wb_clk_i,
  input  logic       reset_n,
  input  logic       gpio_ready,
  input  logic [4:0] pads_n,
  output logic [3:0] keys_n,
  output logic [3:0] key_press,
  output logic       design_reset,
  output logic       armed
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] DB_MAX   = CW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_WAIT, S_RESET, S_HOLD, S_RUN} state_t;

  state_t          state, next_state;
  logic [HW-1:0]   hold_cnt;
  logic [4:0]      pad_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] ready_sync;
  logic [4:0]      pads_s;
  logic            ready_s;
  logic [4:0]      db, db_next;
  logic [CW-1:0]   cnt      [5];
  logic [CW-1:0]   cnt_next [5];
  logic            ext_db;

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) pad_sync[s] <= '1;
      ready_sync <= '0;
    end else begin
      pad_sync[0] <= pads_n;
      for (int s = 1; s < SYNC_STAGES; s++) pad_sync[s] <= pad_sync[s-1];
      ready_sync <= {ready_sync[SYNC_STAGES-2:0], gpio_ready};
    end
  end

  assign pads_s = pad_sync[SYNC_STAGES-1];
  assign ready_s = ready_sync[SYNC_STAGES-1];
  assign ext_db = db[0];
  assign keys_n = db[4:1];

  // Until armed, every channel is pinned released so floating pads are ignored.
  always_comb begin
    db_next = db;
    for (int i = 0; i < 5; i++) cnt_next[i] = cnt[i];
    for (int i = 0; i < 5; i++) begin
      if (state == S_WAIT) begin
        db_next[i]  = 1'b1;
        cnt_next[i] = '0;
      end else if (pads_s[i] == db[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == DB_MAX) begin
        db_next[i]  = pads_s[i];
        cnt_next[i] = '0;
      end else begin
        cnt_next[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      db        <= 5'b11111;
      key_press <= 4'b0000;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      db        <= db_next;
      key_press <= db[4:1] & ~db_next[4:1];
      for (int i = 0; i < 5; i++) cnt[i] <= cnt_next[i];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_WAIT:  if (ready_s) next_state = S_RESET;
      S_RESET: if (ext_db) next_state = S_HOLD;
      S_HOLD: begin
        if (!ext_db) next_state = S_RESET;
        else if (hold_cnt == HOLD_MAX) next_state = S_RUN;
      end
      S_RUN:   if (!ext_db) next_state = S_RESET;
      default: next_state = S_WAIT;
    endcase
  end

  // Outputs load the next-state decode so they come straight off flops.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_WAIT;
      hold_cnt     <= '0;
      design_reset <= 1'b1;
      armed        <= 1'b0;
    end else begin
      state        <= next_state;
      design_reset <= (next_state != S_RUN);
      armed        <= (next_state != S_WAIT);
      if (state == S_RESET) hold_cnt <= '0;
      else if (state == S_HOLD) hold_cnt <= hold_cnt + HW'(1);
    end
  end

endmodule

// File: tb/tb_solo_squash_input_cond.sv
// Directed bench for solo_squash_input_cond: vector table for the main flow,
// hand sequences for glitch rejection, async reset and hold abort.
module tb_solo_squash_input_cond;

  logic       clk;
  logic       reset_n;
  logic       gpio_ready;
  logic [4:0] pads_n;
  logic [3:0] keys_n, key_press;
  logic       design_reset, armed;
  logic [3:0] long_keys_n, long_key_press;
  logic       long_design_reset, long_armed;

  int checks = 0;
  int errors = 0;

  solo_squash_input_cond #(.SYNC_STAGES(2), .DB_CYCLES(4), .HOLD_CYCLES(3)) dut (
    .wb_clk_i(clk), .reset_n(reset_n), .gpio_ready(gpio_ready), .pads_n(pads_n),
    .keys_n(keys_n), .key_press(key_press), .design_reset(design_reset), .armed(armed)
  );

  // A longer hold window makes an abort from S_HOLD reachable with DB_CYCLES=4.
  solo_squash_input_cond #(.SYNC_STAGES(2), .DB_CYCLES(4), .HOLD_CYCLES(8)) dut_long (
    .wb_clk_i(clk), .reset_n(reset_n), .gpio_ready(gpio_ready), .pads_n(pads_n),
    .keys_n(long_keys_n), .key_press(long_key_press),
    .design_reset(long_design_reset), .armed(long_armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] pads;
    logic       ready;
    int         cycles;
    logic [3:0] exp_keys;
    logic [3:0] exp_press;
    logic       exp_dr;
    logic       exp_armed;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string n, input logic [4:0] p, input logic r, input int c,
                        input logic [3:0] k, input logic [3:0] kp, input logic dr, input logic ar);
    vec_t v;
    v.name = n; v.pads = p; v.ready = r; v.cycles = c;
    v.exp_keys = k; v.exp_press = kp; v.exp_dr = dr; v.exp_armed = ar;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [4:0] p, input logic r, input int c);
    pads_n = p;
    gpio_ready = r;
    repeat (c) @(negedge clk);
  endtask

  task automatic checkOutput(input string n, input logic [3:0] k, input logic [3:0] kp,
                             input logic dr, input logic ar);
    checks++;
    if ({keys_n, key_press, design_reset, armed} !== {k, kp, dr, ar}) begin
      errors++;
      $display("[TB] FAIL %s: got keys_n=%b key_press=%b design_reset=%b armed=%b, expected %b %b %b %b",
               n, keys_n, key_press, design_reset, armed, k, kp, dr, ar);
    end
  endtask

  task automatic checkLong(input string n, input logic dr, input logic ar);
    checks++;
    if ({long_design_reset, long_armed} !== {dr, ar}) begin
      errors++;
      $display("[TB] FAIL %s: got design_reset=%b armed=%b, expected %b %b",
               n, long_design_reset, long_armed, dr, ar);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    gpio_ready = 1'b0;
    pads_n = 5'b11111;

    addVec("gate",          5'b00000, 1'b0, 100, 4'b1111, 4'b0000, 1'b1, 1'b0);
    addVec("arm_e2",        5'b11111, 1'b1, 2,   4'b1111, 4'b0000, 1'b1, 1'b0);
    addVec("arm_e3",        5'b11111, 1'b1, 1,   4'b1111, 4'b0000, 1'b1, 1'b1);
    addVec("hold_e6",       5'b11111, 1'b1, 3,   4'b1111, 4'b0000, 1'b1, 1'b1);
    addVec("run_e7",        5'b11111, 1'b1, 1,   4'b1111, 4'b0000, 1'b0, 1'b1);
    addVec("up_e5",         5'b01111, 1'b1, 5,   4'b1111, 4'b0000, 1'b0, 1'b1);
    addVec("up_e6",         5'b01111, 1'b1, 1,   4'b0111, 4'b1000, 1'b0, 1'b1);
    addVec("up_e7",         5'b01111, 1'b1, 1,   4'b0111, 4'b0000, 1'b0, 1'b1);
    addVec("up_rel_e5",     5'b11111, 1'b1, 5,   4'b0111, 4'b0000, 1'b0, 1'b1);
    addVec("up_rel_e6",     5'b11111, 1'b1, 1,   4'b1111, 4'b0000, 1'b0, 1'b1);
    addVec("dual_e6",       5'b10011, 1'b1, 6,   4'b1001, 4'b0110, 1'b0, 1'b1);
    addVec("dual_rel_e6",   5'b11111, 1'b1, 6,   4'b1111, 4'b0000, 1'b0, 1'b1);
    addVec("ext_e6",        5'b11110, 1'b1, 6,   4'b1111, 4'b0000, 1'b0, 1'b1);
    addVec("ext_e7",        5'b11110, 1'b1, 1,   4'b1111, 4'b0000, 1'b1, 1'b1);
    addVec("pause_in_rst",  5'b11100, 1'b1, 6,   4'b1110, 4'b0001, 1'b1, 1'b1);
    addVec("pause_rel_rst", 5'b11110, 1'b1, 6,   4'b1111, 4'b0000, 1'b1, 1'b1);
    addVec("extup_e6",      5'b11111, 1'b1, 6,   4'b1111, 4'b0000, 1'b1, 1'b1);
    addVec("extup_e7",      5'b11111, 1'b1, 1,   4'b1111, 4'b0000, 1'b1, 1'b1);
    addVec("extup_e9",      5'b11111, 1'b1, 2,   4'b1111, 4'b0000, 1'b1, 1'b1);
    addVec("extup_e10",     5'b11111, 1'b1, 1,   4'b1111, 4'b0000, 1'b0, 1'b1);
    addVec("ready_drop",    5'b11111, 1'b0, 10,  4'b1111, 4'b0000, 1'b0, 1'b1);

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_state", 4'b1111, 4'b0000, 1'b1, 1'b0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].pads, vecs[i].ready, vecs[i].cycles);
      checkOutput(vecs[i].name, vecs[i].exp_keys, vecs[i].exp_press,
                  vecs[i].exp_dr, vecs[i].exp_armed);
    end

    // Up key bouncing 3 low / 1 high must never debounce.
    for (int g = 0; g < 10; g++) begin
      for (int c = 0; c < 4; c++) begin
        applyStimulus((c < 3) ? 5'b01111 : 5'b11111, 1'b0, 1);
        checkOutput("glitch", 4'b1111, 4'b0000, 1'b0, 1'b1);
      end
    end
    applyStimulus(5'b11111, 1'b0, 3);
    checkOutput("glitch_settle", 4'b1111, 4'b0000, 1'b0, 1'b1);

    // Async reset while the press pulse is high.
    applyStimulus(5'b01111, 1'b0, 6);
    checkOutput("press_before_rst", 4'b0111, 4'b1000, 1'b0, 1'b1);
    #1 reset_n = 1'b0;
    #1 checkOutput("async_reset", 4'b1111, 4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(5'b11111, 1'b0, 10);
    checkOutput("rewait", 4'b1111, 4'b0000, 1'b1, 1'b0);
    applyStimulus(5'b11111, 1'b1, 2);
    checkOutput("rearm_e2", 4'b1111, 4'b0000, 1'b1, 1'b0);
    applyStimulus(5'b11111, 1'b1, 1);
    checkOutput("rearm_e3", 4'b1111, 4'b0000, 1'b1, 1'b1);
    applyStimulus(5'b11111, 1'b1, 3);
    checkOutput("rearm_e6", 4'b1111, 4'b0000, 1'b1, 1'b1);
    applyStimulus(5'b11111, 1'b1, 1);
    checkOutput("rearm_e7", 4'b1111, 4'b0000, 1'b0, 1'b1);

    // Abort during hold on the long-hold instance.
    reset_n = 1'b0;
    applyStimulus(5'b11111, 1'b0, 1);
    reset_n = 1'b1;
    applyStimulus(5'b11111, 1'b1, 4);
    checkLong("long_hold_e4", 1'b1, 1'b1);
    for (int c = 0; c < 16; c++) begin
      applyStimulus(5'b11110, 1'b1, 1);
      checkLong("long_abort", 1'b1, 1'b1);
    end
    applyStimulus(5'b11111, 1'b1, 14);
    checkLong("long_rehold_e14", 1'b1, 1'b1);
    applyStimulus(5'b11111, 1'b1, 1);
    checkLong("long_run_e15", 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
